// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and FSM states for the multiply/divide unit.
// Optional MADD/MSUB family is enabled by defining MDU_MADD_EN.
package mdu_pkg;

    localparam logic [2:0] MULTU = 3'b000;
    localparam logic [2:0] MULT  = 3'b001;
    localparam logic [2:0] DIVU  = 3'b010;
    localparam logic [2:0] DIV   = 3'b011;
    localparam logic [2:0] MADD  = 3'b100;
    localparam logic [2:0] MADDU = 3'b101;
    localparam logic [2:0] MSUB  = 3'b110;
    localparam logic [2:0] MSUBU = 3'b111;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic op_valid(input logic [2:0] op);
`ifdef MDU_MADD_EN
        op_valid = 1'b1;
`else
        op_valid = ~op[2];
`endif
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        op_is_div = (op == DIVU) || (op == DIV);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result of the latched MDU operation against the current {HI,LO}.
// Accumulating ops (MDU_MADD_EN) fold the product into hilo modulo 2^64.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo,
    output logic [63:0] res,
    output logic        wr
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] qu;
    logic [31:0] ru;
    logic [31:0] q;
    logic [31:0] r;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide runs on magnitudes; 0x80000000 survives negation as its own magnitude.
    always_comb begin
        sdiv = (op == DIV);
        ma   = (sdiv && a[31]) ? (~a + 32'd1) : a;
        mb   = (sdiv && b[31]) ? (~b + 32'd1) : b;
        qu   = 32'd0;
        ru   = 32'd0;
        if (mb != 32'd0) begin
            qu = ma / mb;
            ru = ma % mb;
        end
        q = (sdiv && (a[31] ^ b[31])) ? (~qu + 32'd1) : qu;
        r = (sdiv && a[31]) ? (~ru + 32'd1) : ru;
    end

    always_comb begin
        res = hilo;
        wr  = 1'b1;
        case (op)
            MULTU: res = prod_u;
            MULT:  res = prod_s;
            DIVU, DIV: begin
                res = {r, q};
                wr  = (b != 32'd0);
            end
`ifdef MDU_MADD_EN
            MADD:  res = hilo + prod_s;
            MADDU: res = hilo + prod_u;
            MSUB:  res = hilo - prod_s;
            MSUBU: res = hilo - prod_u;
`endif
            default: wr = 1'b0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers with fixed multi-cycle latency.
// Define MDU_MADD_EN to accept the madd/maddu/msub/msubu op codes.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] a_q, a_n;
    logic [31:0] b_q, b_n;
    logic [2:0]  op_q, op_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;
    logic [63:0] res;
    logic        res_wr;

    mdu_calc u_calc (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hilo ({hi_q, lo_q}),
        .res  (res),
        .wr   (res_wr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            op_q  <= op_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        unique case (state)
            IDLE: begin
                if (start && !flush && op_valid(MDUOp)) begin
                    a_n     = A;
                    b_n     = B;
                    op_n    = MDUOp;
                    cnt_n   = op_is_div(MDUOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_n = RUN;
                end else if (!flush && !start) begin
                    if (HIWrite) hi_n = A;
                    if (LOWrite) lo_n = A;
                end
            end
            RUN: begin
                // Older committed op: flush and new requests cannot disturb it.
                if (cnt <= CW'(1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (res_wr) begin
                        hi_n = res[63:32];
                        lo_n = res[31:0];
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu with hand-computed HI/LO/busy values.
// Covers the MDU_MADD_EN codes when that macro is defined.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic        HIWrite;
    logic        LOWrite;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk;
    int n_fail;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDUOp   (MDUOp),
        .HIWrite (HIWrite),
        .LOWrite (LOWrite),
        .flush   (flush),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check busy every cycle of the run, then check the result.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo);
        MDUOp = op;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'b0, busy}, 32'd1);
            tick();
        end
        chk({tag, " busy_fall"}, {31'b0, busy}, 32'd0);
        chk({tag, " HI"}, HI, ehi);
        chk({tag, " LO"}, LO, elo);
    endtask

    task automatic mtx(input logic hw, input logic lw, input logic [31:0] a);
        HIWrite = hw;
        LOWrite = lw;
        A       = a;
        tick();
        HIWrite = 1'b0;
        LOWrite = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b0;
        start   = 1'b0;
        MDUOp   = 3'b000;
        HIWrite = 1'b0;
        LOWrite = 1'b0;
        flush   = 1'b0;
        A       = '0;
        B       = '0;
        tick();
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst HI", HI, 32'h0);
        chk("rst LO", LO, 32'h0);
        reset = 1'b1;
        tick();

        run_op("mult", 3'b001, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'b000, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("divu", 3'b010, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_neg", 3'b011, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

        mtx(1'b1, 1'b0, 32'h1234_5678);
        chk("mthi HI", HI, 32'h1234_5678);
        chk("mthi busy", {31'b0, busy}, 32'd0);
        mtx(1'b0, 1'b1, 32'h0);
        chk("mtlo LO", LO, 32'h0);
        run_op("divu0", 3'b010, 32'd7, 32'd0, 10, 32'h1234_5678, 32'h0);

        // Flushed start and flushed mtlo both dropped.
        flush = 1'b1;
        MDUOp = 3'b001;
        A     = 32'd3;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start   = 1'b0;
        LOWrite = 1'b1;
        tick();
        LOWrite = 1'b0;
        flush   = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush HI", HI, 32'h1234_5678);
        chk("flush LO", LO, 32'h0);

        // mtlo together with start is ignored; the mult still runs.
        LOWrite = 1'b1;
        run_op("start+mtlo", 3'b000, 32'd6, 32'd7, 5, 32'h0, 32'd42);
        LOWrite = 1'b0;

`ifndef MDU_MADD_EN
        MDUOp = 3'b100;
        A     = 32'd3;
        B     = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("inv busy", {31'b0, busy}, 32'd0);
        chk("inv LO", LO, 32'd42);
`endif

        // Restart during RUN is ignored: mult finishes after exactly 5 cycles.
        MDUOp = 3'b000;
        A     = 32'd3;
        B     = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        MDUOp = 3'b010;
        A     = 32'd9;
        B     = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rerun busy3", {31'b0, busy}, 32'd1);
        tick();
        tick();
        chk("rerun busy5", {31'b0, busy}, 32'd1);
        tick();
        chk("rerun fall", {31'b0, busy}, 32'd0);
        chk("rerun HI", HI, 32'h0);
        chk("rerun LO", LO, 32'd12);

        // Reset mid-run aborts and clears HI/LO.
        mtx(1'b1, 1'b0, 32'hDEAD_BEEF);
        MDUOp = 3'b001;
        A     = 32'd5;
        B     = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_run busy", {31'b0, busy}, 32'd0);
        chk("rst_run HI", HI, 32'h0);
        chk("rst_run LO", LO, 32'h0);
        tick();
        tick();
        chk("rst_run hold", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        tick();

`ifdef MDU_MADD_EN
        mtx(1'b1, 1'b0, 32'h0);
        mtx(1'b0, 1'b1, 32'h1);
        run_op("madd", 3'b100, 32'd3, 32'd4, 5, 32'h0, 32'd13);
        run_op("msub", 3'b110, 32'd2, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("maddu", 3'b101, 32'hFFFF_FFFF, 32'd1, 5, 32'h0, 32'hFFFF_FFFE);
        run_op("msubu", 3'b111, 32'd2, 32'd3, 5, 32'h0, 32'hFFFF_FFF8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
